axi4_mem_slave: RTL and testbench
=================================

Name: axi4_mem_slave

Overview:
AXI4 slave wrapping a word-addressed on-chip memory. It is the downstream target of the AXI4 bench/master traffic in this subsystem. Independent write and read channel FSMs support INCR bursts of up to 256 beats. Out-of-range accesses complete the handshake with SLVERR instead of touching memory.

Parameters:
DATA_WIDTH, 32, data bus width in bits (byte lanes = DATA_WIDTH/8).
ADDR_WIDTH, 16, byte-address width of AWADDR/ARADDR.
MEMORY_DEPTH, 1024, number of DATA_WIDTH-bit words; legal byte range is 0 .. MEMORY_DEPTH*4-1.

Ports:
ACLK  in  1  clock; all logic on rising edge.
ARESET  in  1  synchronous, active-high reset.
AWADDR  in  ADDR_WIDTH  write burst start byte address.
AWLEN  in  8  beats minus 1.
AWSIZE  in  3  bytes per beat = 2**AWSIZE.
AWVALID  in  1  / AWREADY  out  1  write address handshake.
WDATA  in  DATA_WIDTH  / WLAST  in  1  / WVALID  in  1  / WREADY  out  1  write data channel.
BRESP  out  2  / BVALID  out  1  / BREADY  in  1  write response channel.
ARADDR  in  ADDR_WIDTH  / ARLEN  in  8  / ARSIZE  in  3  / ARVALID  in  1  / ARREADY  out  1  read address channel.
RDATA  out  DATA_WIDTH  / RRESP  out  2  / RLAST  out  1  / RVALID  out  1  / RREADY  in  1  read data channel.

Behaviour:
- Reset: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0. BRESP, RRESP = 2'b00. RDATA = 0. Both FSMs go to IDLE. Memory contents are not cleared.
- Reset mid-burst: the burst is aborted. Beats already written stay in memory. No B or R response is issued for the aborted burst.
- Handshake: a transfer occurs on a rising edge with VALID&READY both high. Slave outputs hold stable while VALID=1 and READY=0.
- Write FSM states W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1, from the first cycle after reset deasserts. On the AW handshake, latch addr, len, size; clear beat count and error flag; AWREADY drops next cycle; go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes mem[addr>>2] = WDATA if the beat is legal. Then addr += 2**size and count += 1.
  - W_DATA exit: leave when count == len at the handshake. The beat count is authoritative.
  - WLAST checking: WLAST=0 on the final beat, or WLAST=1 on an earlier beat, sets the error flag and does not end the burst.
  - W_RESP: WREADY=0, BVALID=1. BRESP = 2'b10 (SLVERR) if the error flag is set, else 2'b00. On the B handshake, BVALID=0 and go to W_IDLE.
- Beat legality: a beat is illegal if (addr>>2) >= MEMORY_DEPTH or 2**size > DATA_WIDTH/8. An illegal write beat is accepted but discarded, and sets the error flag.
- Address arithmetic: addr is ADDR_WIDTH bits wide and wraps modulo 2**ADDR_WIDTH. Wrapped beats are then judged by the legality rule. Only INCR bursts are supported.
- Read FSM states R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On the AR handshake, latch the address fields; ARREADY=0; go to R_DATA.
  - First beat: RDATA/RRESP for beat 0 are registered at the AR handshake edge, so RVALID=1 in the next cycle (1-cycle latency).
  - Subsequent beats: on each R handshake, the next beat's data is registered the same edge. Back-to-back beats run at one per cycle while RREADY=1.
  - Illegal read beat: RDATA=0, RRESP=2'b10. Legal beat: RRESP=2'b00.
  - RLAST=1 only on beat len. The handshake of that beat clears RVALID and RLAST and returns to R_IDLE.
- Concurrency: the write and read FSMs run independently and may both be active. A read registered on the same edge as a write to the same word returns the old value.
- Idle gap: one cycle of AWREADY/ARREADY=0 after each address handshake. At most one outstanding burst per direction.

Test Plan:
- Single write then read: AW 0x0010/len0/size2, W 0xDEADBEEF WLAST=1, BREADY=1 -> BRESP=00 one cycle after the W handshake. AR 0x0010 -> RDATA=0xDEADBEEF, RRESP=00, RLAST=1, RVALID one cycle after the AR handshake.
- 4-beat burst: write 0x11,0x22,0x33,0x44 at 0x0100 with len3 -> BRESP=00. Read 0x0100 with len3 and RREADY held 1 -> four consecutive RVALID cycles, data in order, RLAST on the 4th beat.
- Out-of-range: write 0xA5A5A5A5 at 0xFFF1 -> BRESP=10, memory unchanged. Read 0xFFF1 -> RDATA=0, RRESP=10. Repeat at 0x7FFF -> SLVERR both ways.
- Boundary burst: write at 0x0FF8 with len3 -> beats at 0x0FF8 and 0x0FFC written, beats at 0x1000 and 0x1004 dropped, BRESP=10. Reading back 0x0FFC returns its data with RRESP=00.
- Backpressure: hold BREADY=0 for 5 cycles -> BVALID and BRESP stable. Toggle RREADY during a 4-beat read -> RDATA stable while stalled and no beat lost.
- Reset: assert ARESET during beat 2 of an 8-beat write -> all handshake outputs 0 next cycle, no BVALID. After release, AWREADY=1 and beats 0-1 are readable.

Source files
------------

// File: rtl/axi4_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4_mem_slave
// Brief    : AXI4 slave over a word-addressed on-chip memory, INCR bursts,
//            SLVERR for out-of-range or oversized beats.
// Revision : 1.0  initial release
// ============================================================================
module axi4_mem_slave #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY
);

    localparam int          c_BYTES      = DATA_WIDTH / 8;
    localparam int          c_WORD_SHIFT = $clog2(c_BYTES);
    localparam int          c_IDX_W      = $clog2(MEMORY_DEPTH);
    localparam logic [2:0]  c_MAX_SIZE   = 3'(c_WORD_SHIFT);
    localparam logic [31:0] c_DEPTH      = 32'(MEMORY_DEPTH);
    localparam logic [1:0]  c_OKAY       = 2'b00;
    localparam logic [1:0]  c_SLVERR     = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    logic [DATA_WIDTH-1:0] r_mem [0:MEMORY_DEPTH-1];

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wstate_t               r_wstate, w_wstate_nxt;
    logic                  r_awready, r_wready, r_bvalid;
    logic                  w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
    logic [1:0]            r_bresp;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_wlen, r_wcount;
    logic [2:0]            r_wsize;
    logic                  r_werr;

    logic                  w_aw_hs, w_w_hs, w_b_hs;
    logic                  w_wlast_beat, w_wbeat_legal, w_werr_nxt;
    logic [ADDR_WIDTH-1:0] w_wword, w_wstep;

    // Handshakes are masked during reset so a beat on the reset edge is dropped.
    assign w_aw_hs = AWVALID & r_awready & ~ARESET;
    assign w_w_hs  = WVALID  & r_wready  & ~ARESET;
    assign w_b_hs  = r_bvalid & BREADY   & ~ARESET;

    assign w_wword       = r_waddr >> c_WORD_SHIFT;
    assign w_wstep       = ADDR_WIDTH'(1) << r_wsize;
    assign w_wlast_beat  = (r_wcount == r_wlen);
    assign w_wbeat_legal = (32'(w_wword) < c_DEPTH) && (r_wsize <= c_MAX_SIZE);
    assign w_werr_nxt    = r_werr | ~w_wbeat_legal | (WLAST != w_wlast_beat);

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs)                w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_wlast_beat) w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs)                 w_wstate_nxt = W_IDLE;
            default:                             w_wstate_nxt = W_IDLE;
        endcase
        w_awready_nxt = (w_wstate_nxt == W_IDLE);
        w_wready_nxt  = (w_wstate_nxt == W_DATA);
        w_bvalid_nxt  = (w_wstate_nxt == W_RESP);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_OKAY;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            if (w_w_hs && w_wlast_beat)
                r_bresp <= w_werr_nxt ? c_SLVERR : c_OKAY;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wsize  <= '0;
            r_wcount <= '0;
            r_werr   <= 1'b0;
        end else if (w_aw_hs) begin
            r_waddr  <= AWADDR;
            r_wlen   <= AWLEN;
            r_wsize  <= AWSIZE;
            r_wcount <= '0;
            r_werr   <= 1'b0;
        end else if (w_w_hs) begin
            r_waddr  <= r_waddr + w_wstep;
            r_wcount <= r_wcount + 8'd1;
            r_werr   <= w_werr_nxt;
        end
    end

    // Memory is deliberately left out of reset so contents survive it.
    always_ff @(posedge ACLK) begin
        if (w_w_hs && w_wbeat_legal)
            r_mem[w_wword[c_IDX_W-1:0]] <= WDATA;
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rstate_t               r_rstate, w_rstate_nxt;
    logic                  r_arready, r_rvalid, r_rlast;
    logic                  w_arready_nxt, w_rvalid_nxt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [7:0]            r_rlen, r_rcount;
    logic [2:0]            r_rsize;

    logic                  w_ar_hs, w_r_hs, w_rlast_beat, w_rbeat_legal;
    logic [ADDR_WIDTH-1:0] w_rd_addr, w_rd_word;
    logic [2:0]            w_rd_size;

    assign w_ar_hs      = ARVALID & r_arready & ~ARESET;
    assign w_r_hs       = r_rvalid & RREADY   & ~ARESET;
    assign w_rlast_beat = (r_rcount == r_rlen);

    // Address of the beat being fetched: beat 0 comes straight off AR,
    // later beats are prefetched on the handshake of the previous one.
    assign w_rd_addr     = (r_rstate == R_IDLE) ? ARADDR
                                                : r_raddr + (ADDR_WIDTH'(1) << r_rsize);
    assign w_rd_size     = (r_rstate == R_IDLE) ? ARSIZE : r_rsize;
    assign w_rd_word     = w_rd_addr >> c_WORD_SHIFT;
    assign w_rbeat_legal = (32'(w_rd_word) < c_DEPTH) && (w_rd_size <= c_MAX_SIZE);

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs)                w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs && w_rlast_beat) w_rstate_nxt = R_IDLE;
            default:                             w_rstate_nxt = R_IDLE;
        endcase
        w_arready_nxt = (w_rstate_nxt == R_IDLE);
        w_rvalid_nxt  = (w_rstate_nxt == R_DATA);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rdata  <= '0;
            r_rresp  <= c_OKAY;
            r_rlast  <= 1'b0;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rsize  <= '0;
            r_rcount <= '0;
        end else if (w_ar_hs || (w_r_hs && !w_rlast_beat)) begin
            r_rdata <= w_rbeat_legal ? r_mem[w_rd_word[c_IDX_W-1:0]] : '0;
            r_rresp <= w_rbeat_legal ? c_OKAY : c_SLVERR;
            r_raddr <= w_rd_addr;
            if (w_ar_hs) begin
                r_rlen   <= ARLEN;
                r_rsize  <= ARSIZE;
                r_rcount <= '0;
                r_rlast  <= (ARLEN == 8'd0);
            end else begin
                r_rcount <= r_rcount + 8'd1;
                r_rlast  <= ((r_rcount + 8'd1) == r_rlen);
            end
        end else if (w_r_hs) begin
            r_rlast <= 1'b0;
        end
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;
    assign RLAST   = r_rlast;

endmodule
`default_nettype wire

// File: tb/tb_axi4_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_mem_slave
// Brief    : Directed scoreboard bench for axi4_mem_slave.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi4_mem_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [15:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [1:0]  BRESP, RRESP;

    always #5 ACLK = ~ACLK;

    axi4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEMORY_DEPTH(1024)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    int          total = 0;
    int          bad   = 0;
    logic [1:0]  bq[$];
    rexp_t       rq[$];
    rexp_t       mon_e;
    logic [31:0] wbuf [0:15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Scoreboard monitor: compares on each handshake, and checks stalled data.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (BVALID && BREADY) begin
                if (bq.size() == 0) flag("unexpected_b");
                else chk("bresp", 32'(BRESP), 32'(bq.pop_front()));
            end
            if (RVALID) begin
                if (rq.size() == 0) flag("unexpected_r");
                else if (RREADY) begin
                    mon_e = rq.pop_front();
                    chk("rdata", RDATA, mon_e.data);
                    chk("rresp", 32'(RRESP), 32'(mon_e.resp));
                    chk("rlast", 32'(RLAST), 32'(mon_e.last));
                end else begin
                    chk("rdata_stall", RDATA, rq[0].data);
                end
            end
        end
    end

    task automatic send_aw(input logic [15:0] a, input logic [7:0] len, input logic [2:0] sz);
        int n;
        AWADDR = a; AWLEN = len; AWSIZE = sz; AWVALID = 1'b1; n = 0;
        @(negedge ACLK);
        while (!AWREADY && n < 100) begin n++; @(negedge ACLK); end
        if (!AWREADY) flag("aw_timeout");
        @(posedge ACLK); #1 AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic last);
        int n;
        WDATA = d; WLAST = last; WVALID = 1'b1; n = 0;
        @(negedge ACLK);
        while (!WREADY && n < 100) begin n++; @(negedge ACLK); end
        if (!WREADY) flag("w_timeout");
        @(posedge ACLK); #1 WVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [15:0] a, input logic [7:0] len, input logic [2:0] sz);
        int n;
        ARADDR = a; ARLEN = len; ARSIZE = sz; ARVALID = 1'b1; n = 0;
        @(negedge ACLK);
        while (!ARREADY && n < 100) begin n++; @(negedge ACLK); end
        if (!ARREADY) flag("ar_timeout");
        @(posedge ACLK); #1 ARVALID = 1'b0;
    endtask

    // early >= 0 raises WLAST on that beat as well as the real last beat.
    task automatic write_burst(input logic [15:0] a, input logic [7:0] len, input logic [2:0] sz,
                               input logic [1:0] exp_resp, input int early);
        bq.push_back(exp_resp);
        send_aw(a, len, sz);
        for (int i = 0; i <= int'(len); i++)
            send_w(wbuf[i], (i == int'(len)) || (i == early));
        @(negedge ACLK);
        chk("bvalid_latency", 32'(BVALID), 32'd1);
    endtask

    task automatic read_burst(input logic [15:0] a, input logic [7:0] len, input logic [2:0] sz);
        send_ar(a, len, sz);
        @(negedge ACLK);
        chk("rvalid_latency", 32'(RVALID), 32'd1);
    endtask

    task automatic wait_b();
        int n;
        n = 0;
        while (bq.size() != 0 && n < 200) begin @(posedge ACLK); #1; n++; end
        if (bq.size() != 0) begin flag("b_timeout"); bq.delete(); end
    endtask

    task automatic wait_r();
        int n;
        n = 0;
        while (rq.size() != 0 && n < 200) begin @(posedge ACLK); #1; n++; end
        if (rq.size() != 0) begin flag("r_timeout"); rq.delete(); end
    endtask

    task automatic push_r(input logic [31:0] d, input logic [1:0] resp, input logic last);
        rexp_t e;
        e.data = d; e.resp = resp; e.last = last;
        rq.push_back(e);
    endtask

    initial begin
        ARESET = 1'b1;
        AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWVALID = 1'b0;
        WDATA = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARVALID = 1'b0; RREADY = 1'b1;

        // Reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_awready", 32'(AWREADY), 0);
        chk("rst_wready",  32'(WREADY),  0);
        chk("rst_bvalid",  32'(BVALID),  0);
        chk("rst_arready", 32'(ARREADY), 0);
        chk("rst_rvalid",  32'(RVALID),  0);
        chk("rst_rlast",   32'(RLAST),   0);
        chk("rst_bresp",   32'(BRESP),   0);
        chk("rst_rresp",   32'(RRESP),   0);
        chk("rst_rdata",   RDATA,        0);
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK); @(negedge ACLK);
        chk("post_rst_awready", 32'(AWREADY), 1);
        chk("post_rst_arready", 32'(ARREADY), 1);
        @(posedge ACLK); #1;

        // Single write then read
        wbuf[0] = 32'hDEADBEEF;
        write_burst(16'h0010, 8'd0, 3'd2, 2'b00, -1);
        wait_b();
        push_r(32'hDEADBEEF, 2'b00, 1'b1);
        read_burst(16'h0010, 8'd0, 3'd2);
        wait_r();

        // 4-beat burst
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        write_burst(16'h0100, 8'd3, 3'd2, 2'b00, -1);
        wait_b();
        push_r(32'h11, 2'b00, 1'b0); push_r(32'h22, 2'b00, 1'b0);
        push_r(32'h33, 2'b00, 1'b0); push_r(32'h44, 2'b00, 1'b1);
        read_burst(16'h0100, 8'd3, 3'd2);
        wait_r();

        // Out of range, both directions
        wbuf[0] = 32'hA5A5A5A5;
        write_burst(16'hFFF1, 8'd0, 3'd2, 2'b10, -1);
        wait_b();
        push_r(32'h0, 2'b10, 1'b1);
        read_burst(16'hFFF1, 8'd0, 3'd2);
        wait_r();
        write_burst(16'h7FFF, 8'd0, 3'd2, 2'b10, -1);
        wait_b();
        push_r(32'h0, 2'b10, 1'b1);
        read_burst(16'h7FFF, 8'd0, 3'd2);
        wait_r();

        // Burst straddling the top of memory
        wbuf[0] = 32'hB0B00000; wbuf[1] = 32'hB0B00001;
        wbuf[2] = 32'hB0B00002; wbuf[3] = 32'hB0B00003;
        write_burst(16'h0FF8, 8'd3, 3'd2, 2'b10, -1);
        wait_b();
        push_r(32'hB0B00000, 2'b00, 1'b0); push_r(32'hB0B00001, 2'b00, 1'b0);
        push_r(32'h0, 2'b10, 1'b0);        push_r(32'h0, 2'b10, 1'b1);
        read_burst(16'h0FF8, 8'd3, 3'd2);
        wait_r();
        push_r(32'hB0B00001, 2'b00, 1'b1);
        read_burst(16'h0FFC, 8'd0, 3'd2);
        wait_r();

        // Early WLAST: flagged, burst still runs to its length
        wbuf[0] = 32'hC0; wbuf[1] = 32'hC1;
        write_burst(16'h0040, 8'd1, 3'd2, 2'b10, 0);
        wait_b();
        push_r(32'hC0, 2'b00, 1'b0); push_r(32'hC1, 2'b00, 1'b1);
        read_burst(16'h0040, 8'd1, 3'd2);
        wait_r();

        // Beat wider than the bus
        wbuf[0] = 32'h0BAD0BAD;
        write_burst(16'h0080, 8'd0, 3'd3, 2'b10, -1);
        wait_b();
        push_r(32'h0, 2'b10, 1'b1);
        read_burst(16'h0080, 8'd0, 3'd3);
        wait_r();

        // B backpressure
        @(posedge ACLK); #1 BREADY = 1'b0;
        wbuf[0] = 32'h12345678;
        write_burst(16'h0020, 8'd0, 3'd2, 2'b00, -1);
        repeat (5) begin
            @(negedge ACLK);
            chk("bvalid_stall", 32'(BVALID), 1);
            chk("bresp_stall",  32'(BRESP),  0);
        end
        @(posedge ACLK); #1 BREADY = 1'b1;
        wait_b();

        // R backpressure with RREADY toggling
        push_r(32'h11, 2'b00, 1'b0); push_r(32'h22, 2'b00, 1'b0);
        push_r(32'h33, 2'b00, 1'b0); push_r(32'h44, 2'b00, 1'b1);
        RREADY = 1'b0;
        fork
            begin
                read_burst(16'h0100, 8'd3, 3'd2);
                wait_r();
            end
            begin : toggler
                int n;
                n = 0;
                while (rq.size() != 0 && n < 100) begin
                    @(posedge ACLK); #1;
                    RREADY = (n % 2 == 1);
                    n++;
                end
                RREADY = 1'b1;
            end
        join

        // Reset during beat 2 of an 8-beat write
        @(posedge ACLK); #1;
        send_aw(16'h0200, 8'd7, 3'd2);
        send_w(32'h1000, 1'b0);
        send_w(32'h1001, 1'b0);
        WDATA = 32'h1002; WLAST = 1'b0; WVALID = 1'b1; ARESET = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("abort_awready", 32'(AWREADY), 0);
        chk("abort_wready",  32'(WREADY),  0);
        chk("abort_bvalid",  32'(BVALID),  0);
        chk("abort_arready", 32'(ARREADY), 0);
        chk("abort_rvalid",  32'(RVALID),  0);
        @(posedge ACLK); #1 ARESET = 1'b0; WVALID = 1'b0;
        @(negedge ACLK); @(negedge ACLK);
        chk("abort_awready_back", 32'(AWREADY), 1);
        @(posedge ACLK); #1;
        push_r(32'h1000, 2'b00, 1'b0); push_r(32'h1001, 2'b00, 1'b1);
        read_burst(16'h0200, 8'd1, 3'd2);
        wait_r();
        repeat (4) @(posedge ACLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
